// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO status/control slice: pointer-width helper,
// default almost-full/almost-empty offsets and an elaboration-time legality check.
package fifo_pkg;

    // almost_full defaults to DEPTH - AF_OFFSET; almost_empty defaults to AE_DEFAULT
    localparam int unsigned AF_OFFSET  = 4;
    localparam int unsigned AE_DEFAULT = 4;

    // Ceiling log2, never less than 1 so a pointer always has at least one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned rem;
        width = 0;
        rem   = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

    function automatic bit params_legal(input int unsigned depth,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
        return (depth >= 2) && (af_level >= 1) && (af_level <= depth) && (ae_level < depth);
    endfunction

endpackage

`ifndef FIFO_PARAM_CHECK
`define FIFO_PARAM_CHECK(D, AF, AE) \
    if (!fifo_pkg::params_legal((D), (AF), (AE))) begin : g_illegal_params \
        $error("fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination"); \
    end
`endif

// File: rtl/fifo_wrap_ptr.sv
// Storage pointer that advances on inc and wraps from DEPTH-1 back to 0,
// so non-power-of-two depths never address past the last entry.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_wrap_ptr: DEPTH must be at least 2");
    end

    // Explicit compare against the last index rather than binary rollover
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_status_ctrl.sv
// FIFO control/status: gates client requests into storage strobes, tracks occupancy
// and produces registered full/empty/almost flags plus sticky overflow/underflow.
module fifo_status_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = clog2(DEPTH),
    parameter int unsigned AF_LEVEL = DEPTH - AF_OFFSET,
    parameter int unsigned AE_LEVEL = AE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              err_clr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned          CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]     AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]     AE_C    = CNT_W'(AE_LEVEL);

    `FIFO_PARAM_CHECK(DEPTH, AF_LEVEL, AE_LEVEL)

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Acceptance uses registered flags only, so a rejected request cannot slip through
    always_comb begin
        wr_en = wr & ~full_q;
        rd_en = rd & ~empty_q;
    end

    fifo_wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_en),
        .ptr (wr_addr)
    );

    fifo_wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_en),
        .ptr (rd_addr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags come from next-state count so they line up with the registered count
    always_comb begin
        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);
    end

    // A new error in the same cycle as err_clr keeps the flag set
    always_comb begin
        overflow_d  = (wr & full_q) | (overflow_q & ~err_clr);
        underflow_d = (rd & empty_q) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    always_comb begin
        count        = count_q;
        full         = full_q;
        empty        = empty_q;
        almost_full  = almost_full_q;
        almost_empty = almost_empty_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Scoreboard bench for fifo_status_ctrl: a 32-deep and a 5-deep instance driven by
// directed vectors; expected snapshots are queued and checked by a separate monitor.
module tb_fifo_status_ctrl;

    logic clk;
    logic a_rst, a_wr, a_rd, a_clr;
    logic b_rst, b_wr, b_rd, b_clr;

    logic       a_wr_en, a_rd_en, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_wr_addr, a_rd_addr;
    logic [5:0] a_count;

    logic       b_wr_en, b_rd_en, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_wr_addr, b_rd_addr;
    logic [3:0] b_count;

    fifo_status_ctrl #(.DEPTH(32)) u_dut_a (
        .clk (clk), .rst (a_rst), .wr (a_wr), .rd (a_rd), .err_clr (a_clr),
        .wr_en (a_wr_en), .rd_en (a_rd_en), .wr_addr (a_wr_addr), .rd_addr (a_rd_addr),
        .count (a_count), .full (a_full), .empty (a_empty), .almost_full (a_af),
        .almost_empty (a_ae), .overflow (a_ovf), .underflow (a_udf)
    );

    fifo_status_ctrl #(.DEPTH(5)) u_dut_b (
        .clk (clk), .rst (b_rst), .wr (b_wr), .rd (b_rd), .err_clr (b_clr),
        .wr_en (b_wr_en), .rd_en (b_rd_en), .wr_addr (b_wr_addr), .rd_addr (b_rd_addr),
        .count (b_count), .full (b_full), .empty (b_empty), .almost_full (b_af),
        .almost_empty (b_ae), .overflow (b_ovf), .underflow (b_udf)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [26:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [26:0] pack(input logic we, input logic re,
                                         input logic [5:0] wa, input logic [5:0] ra,
                                         input logic [6:0] cnt, input logic f,
                                         input logic e, input logic af, input logic ae,
                                         input logic ov, input logic un);
        return {we, re, wa, ra, cnt, f, e, af, ae, ov, un};
    endfunction

    function automatic string fmt(input logic [26:0] v);
        return $sformatf("we=%b re=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b af=%b ae=%b ovf=%b udf=%b",
                         v[26], v[25], v[24:19], v[18:13], v[12:6], v[5], v[4], v[3], v[2],
                         v[1], v[0]);
    endfunction

    logic [26:0] snap_a, snap_b;
    assign snap_a = pack(a_wr_en, a_rd_en, {1'b0, a_wr_addr}, {1'b0, a_rd_addr}, {1'b0, a_count},
                         a_full, a_empty, a_af, a_ae, a_ovf, a_udf);
    assign snap_b = pack(b_wr_en, b_rd_en, {3'b0, b_wr_addr}, {3'b0, b_rd_addr}, {3'b0, b_count},
                         b_full, b_empty, b_af, b_ae, b_ovf, b_udf);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string name, input bit sel, input bit we, input bit re,
                        input int wa, input int ra, input int cnt, input bit f, input bit e,
                        input bit af, input bit ae, input bit ov, input bit un);
        exp_t x;
        x.name = name;
        x.sel  = sel;
        x.v    = pack(we, re, 6'(wa), 6'(ra), 7'(cnt), f, e, af, ae, ov, un);
        sb.push_back(x);
    endtask

    // Drives one cycle of inputs just after the rising edge; the monitor checks at the falling edge
    task automatic step(input bit sel, input bit wr, input bit rd, input bit clr, input bit rst_v);
        @(posedge clk);
        #1;
        if (sel) begin
            b_rst = rst_v; b_wr = wr; b_rd = rd; b_clr = clr;
            a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
        end else begin
            a_rst = rst_v; a_wr = wr; a_rd = rd; a_clr = clr;
            b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
        end
    endtask

    exp_t        mon_e;
    logic [26:0] mon_act;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = mon_e.sel ? snap_b : snap_a;
            n_tests = n_tests + 1;
            if (mon_act !== mon_e.v) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %s, required %s", mon_e.name, fmt(mon_act), fmt(mon_e.v));
            end
        end
    end

    int addr_seq [13] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};

    initial begin
        a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
        b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset then idle
        step(0, 0, 0, 0, 0); push("t1_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0); push("t1_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        // Fill to 32, then a rejected 33rd write
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 0, 0, 0);
            push($sformatf("t2_wr%0d", i), 0, 1, 0, i, 0, i, 0, i == 0, i >= 28, i <= 4, 0, 0);
        end
        step(0, 1, 0, 0, 0); push("t2_wr_full", 0, 0, 0, 0, 0, 32, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0); push("t2_overflow", 0, 0, 0, 0, 0, 32, 1, 0, 1, 0, 1, 0);

        // Write and read together while full, then clear overflow
        step(0, 1, 1, 0, 0); push("t3_wrrd_full", 0, 0, 1, 0, 0, 32, 1, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0); push("t3_after",     0, 0, 0, 0, 1, 31, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0); push("t3_clr",       0, 0, 0, 0, 1, 31, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0); push("t3_cleared",   0, 0, 0, 0, 1, 31, 0, 0, 1, 0, 0, 0);

        for (int j = 0; j < 31; j++) begin
            step(0, 0, 1, 0, 0);
            push($sformatf("drain%0d", j), 0, 0, 1, 0, 1 + j, 31 - j, 0, 0, (31 - j) >= 28,
                 (31 - j) <= 4, 0, 0);
        end

        // Write and read together while empty; clear racing a new underflow
        step(0, 1, 1, 0, 0); push("t5_wrrd_empty",   0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0); push("t5_rd",           0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 0); push("t5_clr_rd_empty", 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0); push("t5_set_wins",     0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0); push("t5_clr",          0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0); push("t5_cleared",      0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0);

        // Burst to 17 entries, then reset asynchronously mid-cycle
        for (int k = 0; k < 17; k++) begin
            step(0, 1, 0, 0, 0);
            push($sformatf("t6_wr%0d", k), 0, 1, 0, 1 + k, 1, k, 0, k == 0, 0, k <= 4, 0, 0);
        end
        step(0, 1, 0, 0, 0); push("t6_wr_at17",   0, 1, 0, 18, 1, 17, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1); push("t6_async_rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0); push("t6_released",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        // Five-deep instance: addresses must wrap 4 -> 0 (AF_LEVEL=1, AE_LEVEL=4)
        step(1, 0, 0, 0, 0); push("t4_reset", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, 0);
            push($sformatf("t4_wr%0d", i), 1, 1, 0, addr_seq[i], addr_seq[i], 0, 0, 1, 0, 1,
                 0, 0);
            step(1, 0, 1, 0, 0);
            push($sformatf("t4_rd%0d", i), 1, 0, 1, addr_seq[i + 1], addr_seq[i], 1, 0, 0, 1, 1,
                 0, 0);
        end
        step(1, 0, 0, 0, 0); push("t4_end", 1, 0, 0, 2, 2, 0, 0, 1, 0, 1, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests = n_tests + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
